pedestrian_scheduler: RTL and testbench

Frame-rate sequencer for the pedestrian sprites in the road-crossing game. On each frame tick it services every pedestrian in index order: erase the old 4x4 sprite, pulse that pedestrian's can_move, then redraw at the new position. It is the only master of the shared single-pixel VGA plot port and counts pedestrian deaths for the score/lives logic.

---
 rtl/pedestrian_scheduler.sv | 156 +++++++++++++++
 tb/tb_pedestrian_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pedestrian_scheduler.sv
// Frame-rate sequencer for the pedestrian sprites: erase, move strobe, redraw,
// one pedestrian at a time. Sole master of the single-pixel plot port.
module pedestrian_scheduler #(
  parameter int          N_PED      = 4,
  parameter int          TICK_DIV   = 833333,
  parameter logic [2:0]  PED_COLOUR = 3'b111
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [8*N_PED-1:0]   ped_x,
  input  logic [8*N_PED-1:0]   ped_y,
  input  logic [N_PED-1:0]     ped_dead,
  output logic [N_PED-1:0]     can_move,
  output logic                 plot,
  input  logic                 plot_ready,
  output logic [7:0]           plot_x,
  output logic [7:0]           plot_y,
  output logic [2:0]           plot_colour,
  output logic                 busy,
  output logic                 frame_done,
  output logic [7:0]           dead_count,
  output logic                 overrun
);

  localparam int IW = (N_PED > 1) ? $clog2(N_PED) : 1;
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ERASE  = 3'd1;
  localparam logic [2:0] S_MOVE   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DRAW   = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;

  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic [3:0]    pix;
  logic [DW-1:0] div;
  logic          pending;
  logic          tick;
  logic          accept;
  logic          last_ped;
  logic [7:0]    cur_x;
  logic [7:0]    cur_y;
  logic          cur_dead;
  logic [7:0]    dead_q;
  logic          overrun_q;

  // Frame divider: freezes (does not clear) while the game is paused.
  assign tick = enable && (div == DW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (enable) begin
      div <= tick ? '0 : div + 1'b1;
    end
  end

  // Select the pedestrian currently being serviced.
  always_comb begin
    cur_x    = '0;
    cur_y    = '0;
    cur_dead = 1'b0;
    for (int k = 0; k < N_PED; k++) begin
      if (idx == IW'(k)) begin
        cur_x    = ped_x[8*k +: 8];
        cur_y    = ped_y[8*k +: 8];
        cur_dead = ped_dead[k];
      end
    end
  end

  assign plot     = (state == S_ERASE) || (state == S_DRAW);
  assign accept   = plot && plot_ready;
  assign last_ped = (idx == IW'(N_PED - 1));

  // Sprite addressing wraps mod 256; the pixel counter only moves on acceptance,
  // so the address is naturally held across stalls.
  assign plot_x      = plot ? (cur_x + {6'd0, pix[1:0]}) : 8'd0;
  assign plot_y      = plot ? (cur_y + {6'd0, pix[3:2]}) : 8'd0;
  assign plot_colour = (state == S_DRAW) ? PED_COLOUR : 3'b000;

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_NEXT) && last_ped;
  assign dead_count = dead_q;
  assign overrun    = overrun_q;

  always_comb begin
    can_move = '0;
    if (state == S_MOVE) begin
      for (int k = 0; k < N_PED; k++) begin
        can_move[k] = (idx == IW'(k));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      pix       <= '0;
      pending   <= 1'b0;
      overrun_q <= 1'b0;
      dead_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick || pending) begin
            state   <= S_ERASE;
            pending <= 1'b0;
          end
        end
        S_ERASE: begin
          if (accept) begin
            pix <= pix + 1'b1;
            if (pix == 4'd15) state <= S_MOVE;
          end
        end
        S_MOVE: begin
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cur_dead && (dead_q != 8'hFF)) dead_q <= dead_q + 8'd1;
          state <= S_DRAW;
        end
        S_DRAW: begin
          if (accept) begin
            pix <= pix + 1'b1;
            if (pix == 4'd15) state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (last_ped) begin
            idx   <= '0;
            state <= S_IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_ERASE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // One tick may queue behind a running frame; a second one is lost.
      if ((state != S_IDLE) && tick) begin
        if (pending) overrun_q <= 1'b1;
        else         pending   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pedestrian_scheduler.sv
// Bench for pedestrian_scheduler: phase-level reference model plus directed checks.
module tb_pedestrian_scheduler;
  localparam int TD = 200;
  localparam int N  = 4;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] ped_x;
  logic [31:0] ped_y;
  logic [3:0]  ped_dead;
  logic [3:0]  can_move;
  logic        plot;
  logic        plot_ready;
  logic [7:0]  plot_x;
  logic [7:0]  plot_y;
  logic [2:0]  plot_colour;
  logic        busy;
  logic        frame_done;
  logic [7:0]  dead_count;
  logic        overrun;

  pedestrian_scheduler #(.N_PED(N), .TICK_DIV(TD), .PED_COLOUR(3'b111)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ped_x(ped_x), .ped_y(ped_y), .ped_dead(ped_dead),
    .can_move(can_move), .plot(plot), .plot_ready(plot_ready),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
    .busy(busy), .frame_done(frame_done),
    .dead_count(dead_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: frame = N pedestrians x 35 phases; pixel phases advance only when accepted.
  int m_busy = 0, m_s = 0, m_div = 0, m_pend = 0, m_over = 0, m_dead = 0;
  int dead_mode = 0;

  // Observation recorders for directed checks
  int rec_start, rec_fd, rec_after, plot_cnt, cm_n, prev_busy;
  int cm_cyc[8];
  logic [3:0] cm_val[8];
  int rec_e2;
  logic [7:0] e2x[16];
  logic [7:0] e2y[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit is_pix(input int ph);
    return (ph < 16) || (ph >= 18 && ph <= 33);
  endfunction

  task automatic clear_rec();
    rec_start = -1; rec_fd = -1; rec_after = -1; plot_cnt = 0; cm_n = 0;
  endtask

  task automatic model_adv(input logic r, input logic e, input logic rd, input logic [3:0] dd);
    bit t;
    int ph, p;
    if (r) begin
      m_busy = 0; m_s = 0; m_div = 0; m_pend = 0; m_over = 0; m_dead = 0;
      return;
    end
    t = e && (m_div == TD - 1);
    if (e) m_div = t ? 0 : m_div + 1;
    if (m_busy == 0) begin
      if (t || m_pend != 0) begin
        m_busy = 1; m_s = 0; m_pend = 0;
      end
    end else begin
      if (t) begin
        if (m_pend != 0) m_over = 1;
        else             m_pend = 1;
      end
      ph = m_s % 35;
      p  = m_s / 35;
      if (ph == 17 && dd[p] && m_dead < 255) m_dead++;
      if (!is_pix(ph) || rd) m_s++;
      if (m_s == 35 * N) begin
        m_busy = 0; m_s = 0;
      end
    end
  endtask

  task automatic step();
    logic r, e, rd;
    logic [3:0] dd;
    int ph, p, c;
    logic eplot, efd;
    logic [7:0] bx, by, ex, ey;
    logic [2:0] ecol;
    logic [3:0] ecm;
    r = reset; e = enable; rd = plot_ready; dd = ped_dead;
    @(negedge clk);
    cyc++;
    model_adv(r, e, rd, dd);

    ph = m_s % 35;
    p  = m_s / 35;
    eplot = (m_busy != 0) && is_pix(ph);
    c  = (ph < 16) ? ph : ph - 18;
    bx = ped_x[8*p +: 8];
    by = ped_y[8*p +: 8];
    ex = bx + 8'(c % 4);
    ey = by + 8'(c / 4);
    ecol = (ph < 16) ? 3'b000 : 3'b111;
    ecm = ((m_busy != 0) && ph == 16) ? 4'(1 << p) : 4'b0000;
    efd = (m_busy != 0) && ph == 34 && p == N - 1;

    chk("busy", 32'(busy), 32'(m_busy));
    chk("plot", 32'(plot), 32'(eplot));
    if (eplot) chk("pixel", 32'({plot_x, plot_y, plot_colour}), 32'({ex, ey, ecol}));
    chk("can_move", 32'(can_move), 32'(ecm));
    chk("frame_done", 32'(frame_done), 32'(efd));
    chk("dead_count", 32'(dead_count), 32'(m_dead));
    chk("overrun", 32'(overrun), 32'(m_over));

    if (busy && prev_busy == 0) begin
      if (rec_start < 0) rec_start = cyc;
      if (rec_fd >= 0 && rec_after < 0) rec_after = cyc;
    end
    prev_busy = int'(busy);
    if (frame_done && rec_fd < 0) rec_fd = cyc;
    if (plot && rec_fd < 0) plot_cnt++;
    if (can_move != 4'b0000 && cm_n < 8) begin
      cm_cyc[cm_n] = cyc;
      cm_val[cm_n] = can_move;
      cm_n++;
    end
    if (rec_e2 != 0 && m_busy != 0 && p == 2 && ph < 16) begin
      e2x[ph] = plot_x;
      e2y[ph] = plot_y;
    end

    // Pedestrian behaviour: respond to the move strobe with a new position.
    for (int k = 0; k < N; k++) begin
      if (can_move[k]) begin
        ped_x[8*k +: 8] = 8'($urandom);
        ped_y[8*k +: 8] = 8'($urandom);
        if (dead_mode == 0) ped_dead[k] = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  task automatic wait_busy(input string tag);
    int w;
    w = 0;
    while (m_busy == 0 && w < 1000) begin
      step();
      w++;
    end
    chk(tag, 32'(m_busy), 32'd1);
  endtask

  initial begin
    int w;
    clk = 0; reset = 1; enable = 0; plot_ready = 1; ped_dead = 4'b0000;
    prev_busy = 0; rec_e2 = 0;
    for (int k = 0; k < N; k++) begin
      ped_x[8*k +: 8] = 8'(10 * k);
      ped_y[8*k +: 8] = 8'd0;
    end
    clear_rec();

    // Reset state
    repeat (3) step();
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_xy", 32'({plot_x, plot_y, plot_colour}), 32'd0);
    chk("rst_can_move", 32'(can_move), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_dead", 32'(dead_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // First frame timing
    reset = 0; enable = 1; cyc = 0;
    clear_rec();
    w = 0;
    while (rec_fd < 0 && w < 600) begin
      step();
      w++;
    end
    chk("first_start", 32'(rec_start), 32'd200);
    chk("frame_len", 32'(rec_fd - rec_start + 1), 32'd140);
    chk("plot_cycles", 32'(plot_cnt), 32'd128);
    chk("move_count", 32'(cm_n), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("move_onehot", 32'(cm_val[k]), 32'(1 << k));
      chk("move_time", 32'(cm_cyc[k] - rec_start), 32'(16 + 35 * k));
    end

    // Wrapped sprite addressing for pedestrian 2
    step();
    ped_x[8*2 +: 8] = 8'd250;
    ped_y[8*2 +: 8] = 8'd254;
    rec_e2 = 1;
    wait_busy("wrap_start");
    repeat (140) step();
    rec_e2 = 0;
    for (int k = 0; k < 16; k++) begin
      chk("wrap_x", 32'(e2x[k]), 32'((250 + k % 4) % 256));
      chk("wrap_y", 32'(e2y[k]), 32'((254 + k / 4) % 256));
    end

    // Alternating plot_ready: stretched frame with held coordinates
    wait_busy("toggle_start");
    for (int k = 0; k < 600; k++) begin
      plot_ready = ~plot_ready;
      step();
    end
    plot_ready = 1;

    // Enable dropped mid-frame: frame still completes
    wait_busy("en_start");
    repeat (20) step();
    enable = 0;
    repeat (150) step();
    enable = 1;
    repeat (400) step();

    // Randomized ready/enable
    for (int k = 0; k < 4000; k++) begin
      plot_ready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 15) != 0);
      step();
    end
    plot_ready = 1; enable = 1;

    // Two ticks during one stalled frame -> pending, then overrun
    wait_busy("ovr_start");
    plot_ready = 0;
    repeat (450) step();
    clear_rec();
    plot_ready = 1;
    repeat (500) step();
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("restart_gap", 32'(rec_after - rec_fd), 32'd2);
    repeat (300) step();
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Death counter saturation
    dead_mode = 1;
    ped_dead = 4'b1111;
    repeat (70 * TD) step();
    chk("dead_sat", 32'(dead_count), 32'd255);
    ped_dead = 4'b0010;
    repeat (3 * TD) step();
    chk("dead_hold", 32'(dead_count), 32'd255);
    dead_mode = 0;

    // Reset in the middle of a DRAW pass
    w = 0;
    while (!(m_busy != 0 && (m_s % 35) >= 20 && (m_s % 35) <= 30) && w < 1000) begin
      step();
      w++;
    end
    chk("draw_found", 32'(w < 1000), 32'd1);
    reset = 1;
    step();
    reset = 0;
    chk("mid_rst_plot", 32'(plot), 32'd0);
    chk("mid_rst_can_move", 32'(can_move), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_dead", 32'(dead_count), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    clear_rec();
    w = cyc;
    repeat (300) step();
    chk("restart_delay", 32'(rec_start - w), 32'd200);
    chk("restart_idx0", 32'(cm_val[0]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
